pc_unit: RTL

Parametrised program-counter unit for the front end; the next generation of the single-channel PC. Issues fetch addresses to the icache with a valid/ready handshake, waits for the decoder's verdict on each fetched instruction, and either advances by a decoder offset or locks until a branch offset is broadcast on one of `NUM_CDB` common data buses. A ROB redirect overrides everything. All state is held in explicit registers; there are no combinational latches.

---
 rtl/pc_unit_pkg.sv | 23 ++
 rtl/pc_unit_cdb_match.sv | 42 ++++
 rtl/pc_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_unit_pkg
//   Shared definitions for the program-counter unit: default widths, the
//   "no lock" tag value and the FSM state encoding.
//   Optional feature macro used by the unit: PC_CDB_BYPASS_EN.
// ---------------------------------------------------------------------------
package pc_unit_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_LOCK_W  = 5;
    localparam int DEF_NUM_CDB = 2;

    // A ROB tag of zero means "not waiting on anything".
    localparam int NO_LOCK = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_DEC = 2'd2,
        ST_LOCKED   = 2'd3
    } pc_state_e;

endpackage : pc_unit_pkg

// File: rtl/pc_unit_cdb_match.sv
// ---------------------------------------------------------------------------
// cdb_match
//   Combinational search of the common data buses for a given ROB tag.
//   Ports:
//     tag_i        tag to look for (NO_LOCK never matches)
//     cdb_valid_i  per-channel broadcast valid
//     cdb_tag_i    packed channel tags, channel i at [i*LOCK_W +: LOCK_W]
//     cdb_result_i packed channel results, channel i at [i*ADDR_W +: ADDR_W]
//     hit_o        some valid channel carries tag_i
//     result_o     result of the lowest-index matching channel (0 if none)
// ---------------------------------------------------------------------------
module cdb_match
    import pc_unit_pkg::*;
#(
    parameter int NUM_CDB = DEF_NUM_CDB,
    parameter int LOCK_W  = DEF_LOCK_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic [LOCK_W-1:0]         tag_i,
    input  logic [NUM_CDB-1:0]        cdb_valid_i,
    input  logic [NUM_CDB*LOCK_W-1:0] cdb_tag_i,
    input  logic [NUM_CDB*ADDR_W-1:0] cdb_result_i,
    output logic                      hit_o,
    output logic [ADDR_W-1:0]         result_o
);

    // Scan from the highest channel down so that the lowest matching index
    // is the last writer and therefore wins.
    always_comb begin
        hit_o    = 1'b0;
        result_o = '0;
        if (tag_i != LOCK_W'(NO_LOCK)) begin
            for (int i = NUM_CDB - 1; i >= 0; i--) begin
                if (cdb_valid_i[i] && (cdb_tag_i[i*LOCK_W +: LOCK_W] == tag_i)) begin
                    hit_o    = 1'b1;
                    result_o = cdb_result_i[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

endmodule : cdb_match

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//   Front-end program counter. Issues fetch addresses to the icache, waits
//   for the decoder's verdict, then either advances by the decoder offset or
//   locks until the branch offset is broadcast on a CDB. A ROB redirect
//   overrides everything else.
//
//   Optional feature macro: PC_CDB_BYPASS_EN
//     defined   : a CDB match in the same cycle the decoder presents a lock
//                 skips LOCKED and goes straight back to FETCH.
//     undefined : the unit always enters LOCKED on a nonzero dec_lock.
//
//   Handshake: a fetch transfer happens on a rising edge where
//   fetch_valid && fetch_ready && !stall (and no rob_modify); fetch_valid
//   stays high and fetch_pc stays stable until that transfer happens.
//
//   Ports:
//     clk, rst          clock; asynchronous active-low reset
//     fetch_valid/pc    fetch request and address (registered)
//     fetch_ready       icache accepts the request
//     dec_valid/lock/offset  decoder verdict for the last accepted fetch
//     cdb_valid/tag/result   NUM_CDB packed broadcast channels
//     rob_modify/rob_npc     redirect request and target
//     stall             freeze request for FETCH / WAIT_DEC
//     pc_locked         waiting on a CDB tag (registered)
//     dbg_state         current FSM state, for observation only
// ---------------------------------------------------------------------------
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                LOCK_W   = DEF_LOCK_W,
    parameter int                NUM_CDB  = DEF_NUM_CDB,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      fetch_valid,
    output logic [ADDR_W-1:0]         fetch_pc,
    input  logic                      fetch_ready,
    input  logic                      dec_valid,
    input  logic [LOCK_W-1:0]         dec_lock,
    input  logic [ADDR_W-1:0]         dec_offset,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*LOCK_W-1:0] cdb_tag,
    input  logic [NUM_CDB*ADDR_W-1:0] cdb_result,
    input  logic                      rob_modify,
    input  logic [ADDR_W-1:0]         rob_npc,
    input  logic                      stall,
    output logic                      pc_locked,
    output logic [1:0]                dbg_state
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              pc_locked_q, pc_locked_d;

    // Match against the held lock tag (LOCKED state).
    logic              lock_hit;
    logic [ADDR_W-1:0] lock_result;

    cdb_match #(
        .NUM_CDB (NUM_CDB),
        .LOCK_W  (LOCK_W),
        .ADDR_W  (ADDR_W)
    ) u_lock_match (
        .tag_i        (lock_q),
        .cdb_valid_i  (cdb_valid),
        .cdb_tag_i    (cdb_tag),
        .cdb_result_i (cdb_result),
        .hit_o        (lock_hit),
        .result_o     (lock_result)
    );

`ifdef PC_CDB_BYPASS_EN
    // Match against the tag the decoder is presenting right now.
    logic              dec_hit;
    logic [ADDR_W-1:0] dec_result;

    cdb_match #(
        .NUM_CDB (NUM_CDB),
        .LOCK_W  (LOCK_W),
        .ADDR_W  (ADDR_W)
    ) u_dec_match (
        .tag_i        (dec_lock),
        .cdb_valid_i  (cdb_valid),
        .cdb_tag_i    (cdb_tag),
        .cdb_result_i (cdb_result),
        .hit_o        (dec_hit),
        .result_o     (dec_result)
    );
`endif

    // Next-state / next-PC logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lock_d  = lock_q;

        if (state_q == ST_IDLE) begin
            state_d = ST_FETCH;
        end else if (rob_modify) begin
            // Redirect beats CDB and decoder events and ignores stall.
            state_d = ST_FETCH;
            pc_d    = rob_npc;
            lock_d  = LOCK_W'(NO_LOCK);
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (fetch_ready && !stall) begin
                        state_d = ST_WAIT_DEC;
                    end
                end
                ST_WAIT_DEC: begin
                    if (dec_valid && !stall) begin
                        if (dec_lock == LOCK_W'(NO_LOCK)) begin
                            state_d = ST_FETCH;
                            pc_d    = pc_q + dec_offset;
                        end else begin
`ifdef PC_CDB_BYPASS_EN
                            if (dec_hit) begin
                                state_d = ST_FETCH;
                                pc_d    = pc_q + dec_result;
                            end else begin
                                state_d = ST_LOCKED;
                                lock_d  = dec_lock;
                            end
`else
                            state_d = ST_LOCKED;
                            lock_d  = dec_lock;
`endif
                        end
                    end
                end
                ST_LOCKED: begin
                    // CDB matching is deliberately not gated by stall.
                    if (lock_hit) begin
                        state_d = ST_FETCH;
                        pc_d    = pc_q + lock_result;
                        lock_d  = LOCK_W'(NO_LOCK);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs are flops loaded from the next state so they line up
        // exactly with the state register.
        fetch_valid_d = (state_d == ST_FETCH);
        pc_locked_d   = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            lock_q        <= LOCK_W'(NO_LOCK);
            fetch_valid_q <= 1'b0;
            pc_locked_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            lock_q        <= lock_d;
            fetch_valid_q <= fetch_valid_d;
            pc_locked_q   <= pc_locked_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = pc_q;
    assign pc_locked   = pc_locked_q;
    assign dbg_state   = state_q;

endmodule : pc_unit
